// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the stopwatch 7-segment display path.
//   - Active-low segment patterns (bit6..bit0 = g..a) for BCD 0..9, a dash
//     for non-BCD codes, and the all-off pattern.
//   - Anode all-off value for the 4-digit common-anode display.
//   - Pair-select encoding shared with the adjust logic.
//   - Blink phase type used by the scan driver.
// ---------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] BLANK_SEG = 7'h7F;

   localparam logic [3:0] ANODE_OFF = 4'hF;

   // Which digit pair the adjust logic is editing.
   localparam logic SEL_MIN = 1'b0;   // digits 3:2
   localparam logic SEL_SEC = 1'b1;   // digits 1:0

   typedef enum logic {
      PH_VISIBLE = 1'b0,
      PH_BLANK   = 1'b1
   } blink_phase_e;

endpackage : seg7_pkg

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd_i  [3:0]  input digit; codes 10..15 are shown as a dash (g only)
//   seg_o  [6:0]  active-low segments, bit0 = a ... bit6 = g
// ---------------------------------------------------------------------------
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule : bcd_to_seg7

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexes four BCD digits (MM:SS) onto a 4-anode 7-segment display
// and blinks the digit pair being adjusted.
// Ports:
//   clk         master clock
//   rstN        asynchronous active-low reset
//   digit3..0   BCD digits, digit3 = minutes tens ... digit0 = seconds ones
//   blinkEn     adjust mode; enables blanking of the selected pair
//   blinkSel    SEL_MIN = digits 3:2, SEL_SEC = digits 1:0
//   boardAnode  active-low anode enables, bit i lights digit i (registered)
//   segmentLed  active-low segments, bit0 = a ... bit6 = g (registered)
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//   BLINK_DIV    clock cycles per blink half-period (>= 2)
// ---------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic [3:0] digit3,
   input  logic [3:0] digit2,
   input  logic [3:0] digit1,
   input  logic [3:0] digit0,
   input  logic       blinkEn,
   input  logic       blinkSel,
   output logic [3:0] boardAnode,
   output logic [6:0] segmentLed
);

   localparam int unsigned RW = $clog2(REFRESH_DIV);
   localparam int unsigned BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

   if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $error("seg7_scan_driver: REFRESH_DIV must be >= 2");
   end
   if (BLINK_DIV < 2) begin : g_bad_blink_div
      $error("seg7_scan_driver: BLINK_DIV must be >= 2");
   end

   logic [RW-1:0] refresh_q, refresh_d;
   logic [1:0]    scan_q, scan_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   blink_phase_e  phase_q, phase_d;
   logic [3:0]    anode_q, anode_d;
   logic [6:0]    seg_q, seg_d;

   logic [3:0]    cur_digit;
   logic [6:0]    cur_seg;
   logic          in_pair;
   logic          blank;

   // Dwell counter; the scan position steps on its wrap cycle.
   always_comb begin
      refresh_d = refresh_q + RW'(1);
      scan_d    = scan_q;
      if (refresh_q == REFRESH_LAST) begin
         refresh_d = '0;
         scan_d    = scan_q + 2'd1;
      end
   end

   // Blink phase machine: parked in VISIBLE with a cleared counter whenever
   // adjust mode is off, so every adjust session starts with a full visible
   // half-period.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (!blinkEn) begin
         blink_cnt_d = '0;
         phase_d     = PH_VISIBLE;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = (phase_q == PH_VISIBLE) ? PH_BLANK : PH_VISIBLE;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   always_comb begin
      cur_digit = digit0;
      case (scan_q)
         2'd0: cur_digit = digit0;
         2'd1: cur_digit = digit1;
         2'd2: cur_digit = digit2;
         2'd3: cur_digit = digit3;
         default: cur_digit = digit0;
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd_i (cur_digit),
      .seg_o (cur_seg)
   );

   // scan_q[1] is set for the minutes slots (2,3) and clear for seconds (0,1).
   // blinkEn gates the blank directly so dropping adjust mode un-blanks on the
   // very next edge, while the phase register is still being cleared.
   always_comb begin
      in_pair = (blinkSel == SEL_MIN) ? scan_q[1] : ~scan_q[1];
      blank   = blinkEn && (phase_q == PH_BLANK) && in_pair;
      anode_d = blank ? ANODE_OFF : ~(4'b0001 << scan_q);
      seg_d   = blank ? BLANK_SEG : cur_seg;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         refresh_q   <= '0;
         scan_q      <= '0;
         blink_cnt_q <= '0;
         phase_q     <= PH_VISIBLE;
         anode_q     <= ANODE_OFF;
         seg_q       <= BLANK_SEG;
      end else begin
         refresh_q   <= refresh_d;
         scan_q      <= scan_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         anode_q     <= anode_d;
         seg_q       <= seg_d;
      end
   end

   assign boardAnode = anode_q;
   assign segmentLed = seg_q;

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with REFRESH_DIV=4, BLINK_DIV=16.
// A behavioural model derives the expected pins from the number of clock
// edges since reset and the length of the current adjust-mode run.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

   localparam int RD = 4;
   localparam int BD = 16;

   logic       clk = 1'b0;
   logic       rstN;
   logic [3:0] digit3, digit2, digit1, digit0;
   logic       blinkEn, blinkSel;
   logic [3:0] boardAnode;
   logic [6:0] segmentLed;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .REFRESH_DIV (RD),
      .BLINK_DIV   (BD)
   ) dut (
      .clk        (clk),
      .rstN       (rstN),
      .digit3     (digit3),
      .digit2     (digit2),
      .digit1     (digit1),
      .digit0     (digit0),
      .blinkEn    (blinkEn),
      .blinkSel   (blinkSel),
      .boardAnode (boardAnode),
      .segmentLed (segmentLed)
   );

   // Segment table written out from the display's digit shapes.
   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic logic [3:0] ref_anode(input int slot);
      case (slot)
         0: return 4'b1110;
         1: return 4'b1101;
         2: return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   // n = edge index since reset release, e = edge index within the current
   // adjust-mode run.
   function automatic logic [10:0] model_out(input int n, input int e,
                                             input logic en, input logic sel,
                                             input logic [3:0] d3, input logic [3:0] d2,
                                             input logic [3:0] d1, input logic [3:0] d0);
      int slot = (n / RD) % 4;
      bit blank_half = ((e / BD) % 2) == 1;
      bit selected = sel ? (slot <= 1) : (slot >= 2);
      logic [3:0] d;
      case (slot)
         0: d = d0;
         1: d = d1;
         2: d = d2;
         default: d = d3;
      endcase
      if (en && blank_half && selected) return {4'hF, 7'h7F};
      return {ref_anode(slot), ref_seg(d)};
   endfunction

   int         n_edges;
   int         en_edges;
   logic [3:0] exp_an;
   logic [6:0] exp_seg;

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         n_edges  <= 0;
         en_edges <= 0;
         exp_an   <= 4'hF;
         exp_seg  <= 7'h7F;
      end else begin
         {exp_an, exp_seg} <= model_out(n_edges, en_edges, blinkEn, blinkSel,
                                        digit3, digit2, digit1, digit0);
         n_edges  <= n_edges + 1;
         en_edges <= blinkEn ? en_edges + 1 : 0;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] an_t [4];
      logic [6:0] seg_t [4];
      an_t  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seg_t = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
      rstN = 1'b0; blinkEn = 1'b0; blinkSel = 1'b0;
      digit3 = 4'd1; digit2 = 4'd2; digit1 = 4'd3; digit0 = 4'd4;
      repeat (3) tick();
      checks++;
      if ({boardAnode, segmentLed} !== 11'h7FF)
         $display("FAIL reset_hold: got %b/%b required 1111/1111111", boardAnode, segmentLed);
      else passes++;
      rstN = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++;
         if (boardAnode !== an_t[(c / 4) % 4] || segmentLed !== seg_t[(c / 4) % 4])
            $display("FAIL reset_scan c=%0d: got %b/%b required %b/%b", c, boardAnode,
                     segmentLed, an_t[(c / 4) % 4], seg_t[(c / 4) % 4]);
         else passes++;
      end
   endtask

   task automatic test_decode();
      for (int v = 0; v < 16; v++) begin
         int guard = 0;
         while (((n_edges / RD) % 4) != 0 && guard < 64) begin
            tick();
            guard++;
         end
         if (guard >= 64) begin
            checks++;
            $display("FAIL decode_wait v=%0d: got timeout required slot 0", v);
         end
         digit0 = v[3:0];
         tick();
         checks++;
         if (boardAnode !== 4'b1110 || segmentLed !== ref_seg(v[3:0]))
            $display("FAIL decode v=%0d: got %b/%b required 1110/%b", v, boardAnode,
                     segmentLed, ref_seg(v[3:0]));
         else passes++;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 160; c++) begin
         tick();
         checks++;
         if (boardAnode !== exp_an || segmentLed !== exp_seg)
            $display("FAIL random c=%0d: got %b/%b required %b/%b", c, boardAnode,
                     segmentLed, exp_an, exp_seg);
         else passes++;
         digit3 = 4'($urandom_range(0, 15));
         digit2 = 4'($urandom_range(0, 15));
         digit1 = 4'($urandom_range(0, 15));
         digit0 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) blinkEn = ~blinkEn;
         if ($urandom_range(0, 7) == 0) blinkSel = ~blinkSel;
      end
      blinkEn = 1'b0;
      tick();
   endtask

   task automatic test_blink_minutes();
      int blanks [4];
      blanks = '{0, 0, 0, 0};
      digit3 = 4'd5; digit2 = 4'd9; digit1 = 4'd0; digit0 = 4'd7;
      blinkSel = 1'b0;
      blinkEn  = 1'b1;
      for (int c = 0; c < 64; c++) begin
         tick();
         checks++;
         if (boardAnode !== exp_an || segmentLed !== exp_seg)
            $display("FAIL blink_min c=%0d: got %b/%b required %b/%b", c, boardAnode,
                     segmentLed, exp_an, exp_seg);
         else passes++;
         if (boardAnode === 4'hF && segmentLed === 7'h7F) blanks[c / 16]++;
      end
      for (int w = 0; w < 4; w++) begin
         checks++;
         if (blanks[w] !== ((w % 2) ? 8 : 0))
            $display("FAIL blink_min_window w=%0d: got %0d blanked required %0d", w,
                     blanks[w], (w % 2) ? 8 : 0);
         else passes++;
      end
   endtask

   task automatic test_blink_switch();
      int guard = 0;
      // Wait for a BLANK half where the next slot is a seconds digit (lit).
      while (!(((en_edges / BD) % 2) == 1 && ((n_edges / RD) % 4) <= 1) && guard < 64) begin
         tick();
         guard++;
      end
      if (guard >= 64) begin
         checks++;
         $display("FAIL switch_wait: got timeout required blank half");
      end
      blinkSel = 1'b1;
      tick();
      checks++;
      if (boardAnode !== 4'hF || segmentLed !== 7'h7F)
         $display("FAIL switch_sec_blank: got %b/%b required 1111/1111111", boardAnode, segmentLed);
      else passes++;
      guard = 0;
      while (!(((en_edges / BD) % 2) == 1 && ((n_edges / RD) % 4) <= 1 &&
               ((n_edges / RD) % 4) == ((n_edges - 1) / RD) % 4) && guard < 64) begin
         tick();
         guard++;
         checks++;
         if (boardAnode !== exp_an || segmentLed !== exp_seg)
            $display("FAIL switch_track: got %b/%b required %b/%b", boardAnode, segmentLed,
                     exp_an, exp_seg);
         else passes++;
      end
      if (guard >= 64) begin
         checks++;
         $display("FAIL switch_wait2: got timeout required blank half");
      end
      blinkEn = 1'b0;
      tick();
      checks++;
      if (boardAnode === 4'hF || boardAnode !== exp_an || segmentLed !== exp_seg)
         $display("FAIL blink_off: got %b/%b required %b/%b", boardAnode, segmentLed,
                  exp_an, exp_seg);
      else passes++;
      for (int c = 0; c < 16; c++) begin
         tick();
         checks++;
         if (boardAnode === 4'hF)
            $display("FAIL blink_off_lit c=%0d: got %b required one anode low", c, boardAnode);
         else passes++;
      end
   endtask

   task automatic test_async_reset();
      int guard = 0;
      digit3 = 4'd8; digit2 = 4'd6; digit1 = 4'd2; digit0 = 4'd3;
      while (((n_edges / RD) % 4) != 2 && guard < 64) begin
         tick();
         guard++;
      end
      if (guard >= 64) begin
         checks++;
         $display("FAIL areset_wait: got timeout required slot 2");
      end
      tick();
      checks++;
      if (boardAnode !== 4'b1011 || segmentLed !== ref_seg(4'd6))
         $display("FAIL areset_pre: got %b/%b required 1011/%b", boardAnode, segmentLed,
                  ref_seg(4'd6));
      else passes++;
      #2 rstN = 1'b0;
      #1;
      checks++;
      if (boardAnode !== 4'hF || segmentLed !== 7'h7F)
         $display("FAIL areset_async: got %b/%b required 1111/1111111", boardAnode, segmentLed);
      else passes++;
      tick();
      rstN = 1'b1;
      tick();
      checks++;
      if (boardAnode !== 4'b1110 || segmentLed !== ref_seg(4'd3))
         $display("FAIL areset_first: got %b/%b required 1110/%b", boardAnode, segmentLed,
                  ref_seg(4'd3));
      else passes++;
   endtask

   task automatic test_live_update();
      int guard = 0;
      while ((n_edges % (4 * RD)) != 0 && guard < 64) begin
         tick();
         guard++;
      end
      if (guard >= 64) begin
         checks++;
         $display("FAIL live_wait: got timeout required dwell start");
      end
      digit0 = 4'd5;
      tick();
      checks++;
      if (boardAnode !== 4'b1110 || segmentLed !== 7'b0010010)
         $display("FAIL live_before: got %b/%b required 1110/0010010", boardAnode, segmentLed);
      else passes++;
      digit0 = 4'd9;
      tick();
      checks++;
      if (boardAnode !== 4'b1110 || segmentLed !== 7'b0010000)
         $display("FAIL live_after: got %b/%b required 1110/0010000", boardAnode, segmentLed);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_random();
      test_blink_minutes();
      test_blink_switch();
      test_async_reset();
      test_live_update();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_seg7_scan_driver
